// File: rtl/layered_beam_compositor.sv
// rtl/layered_beam_compositor.sv - two-stage priority layer compositor with highlight boost and frame-synchronous fade
module layered_beam_compositor #(
    parameter int LAYERS                  = 4,
    parameter int COLOR_BITS              = 4,
    parameter int X_BITS                  = 11,
    parameter int Y_BITS                  = 10,
    parameter int GAME_VIEW_LEFT_BORDER_X = 160,
    parameter int GAME_VIEW_RIGHT_BORDER_X = 480,
    parameter int HIGHLIGHT_ADD           = 7,
    parameter int HIGHLIGHT_CAP           = 13,
    parameter int FADE_STEP_FRAMES        = 4,
    localparam int HL_BITS                = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             draw,
    input  logic [X_BITS-1:0]                beam_x,
    input  logic [Y_BITS-1:0]                beam_y,
    input  logic [LAYERS*3*COLOR_BITS-1:0]   layer_colors,
    input  logic [LAYERS-1:0]                layer_transparencies,
    input  logic [LAYERS-1:0]                layer_enable,
    input  logic                             highlight_en,
    input  logic [HL_BITS-1:0]               highlight_layer,
    input  logic                             frame_start,
    input  logic                             fade_out_req,
    input  logic                             fade_in_req,
    output logic [COLOR_BITS-1:0]            red,
    output logic [COLOR_BITS-1:0]            green,
    output logic [COLOR_BITS-1:0]            blue,
    output logic                             out_draw,
    output logic [COLOR_BITS-1:0]            fade_level,
    output logic                             fade_busy
);

    localparam int PIX_BITS      = 3 * COLOR_BITS;
    localparam int CAP_MINUS_ADD = HIGHLIGHT_CAP - HIGHLIGHT_ADD;
    localparam int CNT_BITS      = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;

    localparam logic [COLOR_BITS-1:0] MAX_C    = '1;
    localparam logic [COLOR_BITS-1:0] ONE_C    = COLOR_BITS'(1);
    localparam logic [COLOR_BITS-1:0] CAP_C    = COLOR_BITS'(HIGHLIGHT_CAP);
    localparam logic [COLOR_BITS-1:0] ADD_C    = COLOR_BITS'(HIGHLIGHT_ADD);
    localparam logic [X_BITS-1:0]     LEFT_X   = X_BITS'(GAME_VIEW_LEFT_BORDER_X);
    localparam logic [X_BITS-1:0]     RIGHT_X  = X_BITS'(GAME_VIEW_RIGHT_BORDER_X);
    localparam logic [CNT_BITS-1:0]   CNT_LAST = CNT_BITS'(FADE_STEP_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FADING_OUT = 2'd1,
        DARK       = 2'd2,
        FADING_IN  = 2'd3
    } fade_state_t;

    // Saturating boost; the comparison is done in int so c+ADD never wraps.
    function automatic logic [COLOR_BITS-1:0] boost(input logic [COLOR_BITS-1:0] c);
        if (int'(c) <= CAP_MINUS_ADD) begin
            boost = c + ADD_C;
        end else begin
            boost = CAP_C;
        end
    endfunction

    // Brightness scaling by subtracting the distance from full level, floored at 0.
    function automatic logic [COLOR_BITS-1:0] dim(input logic [COLOR_BITS-1:0] c,
                                                 input logic [COLOR_BITS-1:0] lvl);
        logic [COLOR_BITS-1:0] gap;
        gap = MAX_C - lvl;
        dim = (c > gap) ? (c - gap) : '0;
    endfunction

    logic                  sel_found;
    int                    sel_idx;
    logic [PIX_BITS-1:0]   sel_rgb;
    logic                  in_view;
    logic                  hl_hit;
    logic [PIX_BITS-1:0]   s1_rgb_d;

    logic                  s1_valid_q;
    logic [PIX_BITS-1:0]   s1_rgb_q;
    logic [Y_BITS-1:0]     s1_y_q;
    logic [Y_BITS-1:0]     s2_y_q;

    logic [COLOR_BITS-1:0] red_q, green_q, blue_q;
    logic                  out_draw_q;

    fade_state_t           state_q;
    logic [COLOR_BITS-1:0] level_q;
    logic [CNT_BITS-1:0]   cnt_q;
    logic                  busy_q;

    // Stage 1 select: lowest-index visible layer wins, border and blanking force black.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 0;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (layer_enable[i] && !layer_transparencies[i]) begin
                sel_found = 1'b1;
                sel_idx   = i;
            end
        end
        sel_rgb  = layer_colors[sel_idx*PIX_BITS +: PIX_BITS];
        in_view  = (beam_x > LEFT_X) && (beam_x < RIGHT_X);
        hl_hit   = highlight_en && sel_found && (int'(highlight_layer) == sel_idx);
        s1_rgb_d = '0;
        if (draw && in_view) begin
            if (!sel_found) begin
                s1_rgb_d = '1;
            end else if (hl_hit) begin
                s1_rgb_d = {boost(sel_rgb[2*COLOR_BITS +: COLOR_BITS]),
                            boost(sel_rgb[COLOR_BITS +: COLOR_BITS]),
                            boost(sel_rgb[0 +: COLOR_BITS])};
            end else begin
                s1_rgb_d = sel_rgb;
            end
        end
    end

    // Stage 1 register: selected colour, draw qualifier and row travel together.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_rgb_q   <= '0;
            s1_y_q     <= '0;
        end else begin
            s1_valid_q <= draw;
            s1_rgb_q   <= s1_rgb_d;
            s1_y_q     <= beam_y;
        end
    end

    // Stage 2 register: apply the current fade level and drive the DAC outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_draw_q <= 1'b0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            s2_y_q     <= '0;
        end else begin
            out_draw_q <= s1_valid_q;
            s2_y_q     <= s1_y_q;
            if (s1_valid_q) begin
                red_q   <= dim(s1_rgb_q[2*COLOR_BITS +: COLOR_BITS], level_q);
                green_q <= dim(s1_rgb_q[COLOR_BITS +: COLOR_BITS], level_q);
                blue_q  <= dim(s1_rgb_q[0 +: COLOR_BITS], level_q);
            end else begin
                red_q   <= '0;
                green_q <= '0;
                blue_q  <= '0;
            end
        end
    end

    // Fade FSM: requests take precedence over frame steps; fade_in beats fade_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            level_q <= MAX_C;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fade_out_req && !fade_in_req) begin
                        state_q <= FADING_OUT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                FADING_OUT: begin
                    if (fade_in_req) begin
                        state_q <= FADING_IN;
                        cnt_q   <= '0;
                    end else if (frame_start) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= '0;
                            if (level_q <= ONE_C) begin
                                level_q <= '0;
                                state_q <= DARK;
                                busy_q  <= 1'b0;
                            end else begin
                                level_q <= level_q - ONE_C;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DARK: begin
                    if (fade_in_req) begin
                        state_q <= FADING_IN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                FADING_IN: begin
                    if (fade_out_req && !fade_in_req) begin
                        state_q <= FADING_OUT;
                        cnt_q   <= '0;
                    end else if (frame_start) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= '0;
                            if (level_q >= MAX_C - ONE_C) begin
                                level_q <= MAX_C;
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                level_q <= level_q + ONE_C;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    level_q <= MAX_C;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign out_draw   = out_draw_q;
    assign fade_level = level_q;
    assign fade_busy  = busy_q;

endmodule

// File: tb/tb_layered_beam_compositor.sv
// tb/tb_layered_beam_compositor.sv - vector table, fade sequences and randomized model check for the compositor
module tb_layered_beam_compositor;

    logic        clk = 1'b0;
    logic        rst, draw, hl_en, frame_start, fo_req, fi_req;
    logic [10:0] beam_x;
    logic [9:0]  beam_y;
    logic [47:0] layer_colors;
    logic [3:0]  transp, enable;
    logic [1:0]  hl_layer;

    logic [3:0]  r_a, g_a, b_a, lvl_a, r_b, g_b, b_b, lvl_b;
    logic        od_a, busy_a, od_b, busy_b;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    always #5 clk = ~clk;

    layered_beam_compositor #(.FADE_STEP_FRAMES(1)) dut_a (
        .clk(clk), .rst(rst), .draw(draw), .beam_x(beam_x), .beam_y(beam_y),
        .layer_colors(layer_colors), .layer_transparencies(transp), .layer_enable(enable),
        .highlight_en(hl_en), .highlight_layer(hl_layer), .frame_start(frame_start),
        .fade_out_req(fo_req), .fade_in_req(fi_req),
        .red(r_a), .green(g_a), .blue(b_a), .out_draw(od_a), .fade_level(lvl_a), .fade_busy(busy_a));

    layered_beam_compositor #(.FADE_STEP_FRAMES(4)) dut_b (
        .clk(clk), .rst(rst), .draw(draw), .beam_x(beam_x), .beam_y(beam_y),
        .layer_colors(layer_colors), .layer_transparencies(transp), .layer_enable(enable),
        .highlight_en(hl_en), .highlight_layer(hl_layer), .frame_start(frame_start),
        .fade_out_req(fo_req), .fade_in_req(fi_req),
        .red(r_b), .green(g_b), .blue(b_b), .out_draw(od_b), .fade_level(lvl_b), .fade_busy(busy_b));

    // Reference model. States: 0 idle, 1 fading out, 2 dark, 3 fading in.
    int step_frames[2] = '{1, 4};
    int m_state[2]     = '{0, 0};
    int m_level[2]     = '{15, 15};
    int m_cnt[2]       = '{0, 0};
    bit m_s1_v         = 1'b0;
    int m_s1[3]        = '{0, 0, 0};

    function automatic int chan(input logic [47:0] lc, input int layer, input int ch);
        return int'(lc[layer*12 + (2-ch)*4 +: 4]);
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d exp=%0d", nm, cycle, got, exp);
        end
    endtask

    task automatic step();
        int          e_rgb[2][3];
        bit          e_od;
        int          ns[3];
        int          sel;
        int          v;
        bit          in_ok, out_ok;
        logic [17:0] got, exp;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) begin
                v = m_s1[c] - (15 - m_level[k]);
                e_rgb[k][c] = (!rst && m_s1_v && v > 0) ? v : 0;
            end
        end
        e_od = !rst && m_s1_v;
        sel = -1;
        for (int i = 0; i < 4; i++) begin
            if (sel < 0 && enable[i] && !transp[i]) sel = i;
        end
        for (int c = 0; c < 3; c++) begin
            if (rst || !draw || beam_x <= 160 || beam_x >= 480) ns[c] = 0;
            else if (sel < 0) ns[c] = 15;
            else begin
                ns[c] = chan(layer_colors, sel, c);
                if (hl_en && int'(hl_layer) == sel) ns[c] = (ns[c] + 7 > 13) ? 13 : ns[c] + 7;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_state[k] = 0; m_level[k] = 15; m_cnt[k] = 0;
            end else begin
                in_ok  = fi_req && (m_state[k] == 1 || m_state[k] == 2);
                out_ok = fo_req && !fi_req && (m_state[k] == 0 || m_state[k] == 3);
                if (in_ok) begin
                    m_state[k] = 3; m_cnt[k] = 0;
                end else if (out_ok) begin
                    m_state[k] = 1; m_cnt[k] = 0;
                end else if (frame_start && (m_state[k] == 1 || m_state[k] == 3)) begin
                    if (m_cnt[k] == step_frames[k] - 1) begin
                        m_cnt[k] = 0;
                        if (m_state[k] == 1) begin
                            m_level[k] = (m_level[k] > 0) ? m_level[k] - 1 : 0;
                            if (m_level[k] == 0) m_state[k] = 2;
                        end else begin
                            m_level[k] = (m_level[k] < 15) ? m_level[k] + 1 : 15;
                            if (m_level[k] == 15) m_state[k] = 0;
                        end
                    end else begin
                        m_cnt[k]++;
                    end
                end
            end
        end
        m_s1_v = !rst && draw;
        for (int c = 0; c < 3; c++) m_s1[c] = ns[c];
        @(posedge clk);
        #1;
        cycle++;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) got = {r_a, g_a, b_a, od_a, lvl_a, busy_a};
            else        got = {r_b, g_b, b_b, od_b, lvl_b, busy_b};
            exp = {4'(e_rgb[k][0]), 4'(e_rgb[k][1]), 4'(e_rgb[k][2]), e_od,
                   4'(m_level[k]), (m_state[k] == 1 || m_state[k] == 3)};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL model_%0d cycle=%0d got=%h exp=%h", k, cycle, got, exp);
            end
        end
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic set_pixel(input logic [11:0] l0, input logic [11:0] l1,
                             input logic [3:0] tr, input logic [3:0] en);
        draw = 1'b1; beam_x = 11'd200; hl_en = 1'b0; hl_layer = 2'd0;
        layer_colors = {12'h000, 12'h000, l1, l0};
        transp = tr; enable = en;
    endtask

    typedef struct {
        bit          draw;
        int          x;
        logic [11:0] l0, l1, l2;
        logic [3:0]  tr, en;
        bit          hl;
        int          hl_layer;
        int          er, eg, eb;
        bit          eod;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{1, 200, 12'h345, 12'h999, 12'h000, 4'b0000, 4'b1111, 0, 0,  3,  4,  5, 1});
        vecs.push_back('{1, 200, 12'h345, 12'h999, 12'h000, 4'b0000, 4'b1110, 0, 0,  9,  9,  9, 1});
        vecs.push_back('{1, 200, 12'h345, 12'h999, 12'h000, 4'b1111, 4'b1111, 0, 0, 15, 15, 15, 1});
        vecs.push_back('{1, 160, 12'h345, 12'h999, 12'h000, 4'b0000, 4'b1111, 0, 0,  0,  0,  0, 1});
        vecs.push_back('{1, 480, 12'h345, 12'h999, 12'h000, 4'b0000, 4'b1111, 0, 0,  0,  0,  0, 1});
        vecs.push_back('{1, 161, 12'h345, 12'h999, 12'h000, 4'b0000, 4'b1111, 0, 0,  3,  4,  5, 1});
        vecs.push_back('{1, 479, 12'h345, 12'h999, 12'h000, 4'b0000, 4'b1111, 0, 0,  3,  4,  5, 1});
        vecs.push_back('{0, 200, 12'h345, 12'h999, 12'h000, 4'b0000, 4'b1111, 0, 0,  0,  0,  0, 0});
        vecs.push_back('{1, 200, 12'h345, 12'h26A, 12'h000, 4'b0001, 4'b1111, 1, 1,  9, 13, 13, 1});
        vecs.push_back('{1, 200, 12'h345, 12'h26A, 12'h000, 4'b0001, 4'b1111, 1, 0,  2,  6, 10, 1});
        vecs.push_back('{1, 200, 12'h345, 12'h26A, 12'h000, 4'b0001, 4'b1111, 1, 2,  2,  6, 10, 1});
        vecs.push_back('{1, 200, 12'h345, 12'h26A, 12'h000, 4'b1111, 4'b1111, 1, 1, 15, 15, 15, 1});
        vecs.push_back('{1, 160, 12'h345, 12'h26A, 12'h000, 4'b0001, 4'b1111, 1, 1,  0,  0,  0, 1});
        vecs.push_back('{1, 200, 12'h345, 12'h999, 12'h70C, 4'b1011, 4'b1111, 0, 0,  7,  0, 12, 1});
        vecs.push_back('{1, 200, 12'h670, 12'h999, 12'h000, 4'b0000, 4'b1111, 1, 0, 13, 13,  7, 1});
        vecs.push_back('{1, 200, 12'h345, 12'h999, 12'h000, 4'b0000, 4'b0000, 0, 0, 15, 15, 15, 1});

        rst = 1'b1; draw = 1'b0; beam_x = '0; beam_y = '0; layer_colors = '0;
        transp = '0; enable = '0; hl_en = 1'b0; hl_layer = '0;
        frame_start = 1'b0; fo_req = 1'b0; fi_req = 1'b0;
        step();
        step();
        chk("reset_red", r_a, 0);
        chk("reset_out_draw", od_a, 0);
        chk("reset_level", lvl_a, 15);
        chk("reset_busy", busy_a, 0);
        rst = 1'b0;

        foreach (vecs[n]) begin
            draw = vecs[n].draw; beam_x = 11'(vecs[n].x); beam_y = 10'(n);
            layer_colors = {12'h000, vecs[n].l2, vecs[n].l1, vecs[n].l0};
            transp = vecs[n].tr; enable = vecs[n].en;
            hl_en = vecs[n].hl; hl_layer = 2'(vecs[n].hl_layer);
            step();
            step();
            chk($sformatf("vec%0d_red", n), r_a, vecs[n].er);
            chk($sformatf("vec%0d_green", n), g_a, vecs[n].eg);
            chk($sformatf("vec%0d_blue", n), b_a, vecs[n].eb);
            chk($sformatf("vec%0d_out_draw", n), od_a, vecs[n].eod);
        end
        draw = 1'b0; hl_en = 1'b0;

        fo_req = 1'b1; step(); fo_req = 1'b0;
        chk("fade_out_busy", busy_a, 1);
        chk("fade_out_start_level", lvl_a, 15);
        for (int i = 1; i <= 15; i++) begin
            pulse_fs();
            chk($sformatf("fade_out_level%0d", i), lvl_a, 15 - i);
            if (i == 5) begin
                set_pixel(12'hF83, 12'h000, 4'b0000, 4'b1111);
                step();
                step();
                chk("dim_red", r_a, 10);
                chk("dim_green", g_a, 3);
                chk("dim_blue", b_a, 0);
                draw = 1'b0;
            end
        end
        chk("dark_busy", busy_a, 0);

        fi_req = 1'b1; fo_req = 1'b1; step(); fi_req = 1'b0; fo_req = 1'b0;
        chk("both_req_busy", busy_a, 1);
        chk("both_req_level", lvl_a, 0);
        for (int i = 0; i < 3; i++) pulse_fs();
        chk("fade_in_level3", lvl_a, 3);
        fo_req = 1'b1; step(); fo_req = 1'b0;
        chk("reverse_level", lvl_a, 3);
        chk("reverse_busy", busy_a, 1);
        pulse_fs();
        chk("reverse_step", lvl_a, 2);

        fi_req = 1'b1; step(); fi_req = 1'b0;
        for (int i = 0; i < 13; i++) pulse_fs();
        chk("fade_in_full", lvl_a, 15);
        chk("fade_in_done_busy", busy_a, 0);

        fo_req = 1'b1; step(); fo_req = 1'b0;
        for (int i = 0; i < 9; i++) pulse_fs();
        chk("pre_reset_level", lvl_a, 6);
        set_pixel(12'h345, 12'h000, 4'b0000, 4'b1111);
        step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_reset_level", lvl_a, 15);
        chk("mid_reset_busy", busy_a, 0);
        chk("mid_reset_red0", r_a, 0);
        chk("mid_reset_draw0", od_a, 0);
        step();
        chk("mid_reset_red1", r_a, 0);
        chk("mid_reset_draw1", od_a, 0);
        step();
        chk("post_reset_red", r_a, 3);
        chk("post_reset_draw", od_a, 1);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            draw = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0: beam_x = 11'($urandom_range(159, 161));
                1: beam_x = 11'($urandom_range(479, 481));
                default: beam_x = 11'($urandom_range(0, 640));
            endcase
            beam_y = 10'($urandom);
            layer_colors = 48'({$urandom(), $urandom()});
            transp = 4'($urandom);
            enable = 4'($urandom | $urandom);
            hl_en = 1'($urandom);
            hl_layer = 2'($urandom);
            frame_start = ($urandom_range(0, 2) == 0);
            fo_req = ($urandom_range(0, 59) == 0);
            fi_req = ($urandom_range(0, 79) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/layered_beam_compositor.md
Name: layered_beam_compositor

Overview:
- Parametrised, pipelined pixel compositor for the VGA beam path.
- Merges LAYERS colour sources by fixed priority (layer 0 highest) and blanks outside the game view.
- Applies an optional highlight boost to one selectable layer and a frame-synchronous fade-out/fade-in of the whole picture, driven by a state machine.
- Sits between the sprite/tabloid/platform generators and the VGA DAC pins.

Parameters:
LAYERS, 4, number of colour layers; index 0 has highest priority
COLOR_BITS, 4, bits per colour channel
X_BITS, 11, beam_x width
Y_BITS, 10, beam_y width
GAME_VIEW_LEFT_BORDER_X, 160, pixels with beam_x <= this are black
GAME_VIEW_RIGHT_BORDER_X, 480, pixels with beam_x >= this are black
HIGHLIGHT_ADD, 7, value added to each channel of the highlighted layer
HIGHLIGHT_CAP, 13, saturation value for highlighted channels
FADE_STEP_FRAMES, 4, frames per fade level step (>=1)

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
draw  in  1  beam inside visible area
beam_x  in  X_BITS  current beam column
beam_y  in  Y_BITS  current beam row (pipelined alongside the pixel; reserved for later use)
layer_colors  in  LAYERS*3*COLOR_BITS  per layer {R,G,B}; channel 0 = red
layer_transparencies  in  LAYERS  1 = layer transparent at this pixel
layer_enable  in  LAYERS  0 = layer ignored (treated as transparent)
highlight_en  in  1  enable highlight boost
highlight_layer  in  $clog2(LAYERS)  layer receiving the boost
frame_start  in  1  one-cycle pulse at the start of each frame
fade_out_req  in  1  pulse: begin fading to black
fade_in_req  in  1  pulse: begin fading back to full brightness
red, green, blue  out  COLOR_BITS each  registered pixel colour
out_draw  out  1  draw delayed to align with the colour outputs
fade_level  out  COLOR_BITS  current brightness; max = full, 0 = black
fade_busy  out  1  high in FADING_OUT or FADING_IN

Behaviour:
- Reset (rst=1 at a clk edge):
  - red/green/blue = 0, out_draw = 0.
  - Both pipeline stages cleared; draw-valid of each stage = 0.
  - Fade state = IDLE, fade_level = 2^COLOR_BITS-1, frame counter = 0, fade_busy = 0.
- Latency: exactly 2 clk from inputs to red/green/blue/out_draw. Fully pipelined, one pixel per cycle, no stalls.
- Stage 1 (select):
  - Background is all-ones on every channel.
  - If draw = 0 -> colour 0.
  - Else if beam_x <= LEFT or beam_x >= RIGHT -> colour 0.
  - Else the lowest index i with layer_enable[i]=1 and layer_transparencies[i]=0 supplies the colour.
  - If no layer qualifies -> background.
  - If highlight_en = 1 and the selected i == highlight_layer: each channel c becomes (c <= HIGHLIGHT_CAP-HIGHLIGHT_ADD) ? c+HIGHLIGHT_ADD : HIGHLIGHT_CAP. Computed without width overflow.
  - Border pixels and the background are never boosted.
  - highlight_layer >= LAYERS never matches any layer.
- Stage 2 (fade):
  - Each channel out = (c > M-fade_level) ? c-(M-fade_level) : 0, where M = 2^COLOR_BITS-1.
  - Uses the fade_level register value in the same cycle.
  - Pixels with draw = 0 stay 0.
- Fade FSM; a step occurs on a frame_start pulse when frame counter == FADE_STEP_FRAMES-1; the counter increments on each other frame_start.
  - IDLE: level = M. fade_out_req -> FADING_OUT, counter = 0.
  - FADING_OUT: each step decrements level. When a step reaches 0 -> DARK. fade_in_req -> FADING_IN, counter = 0, level held.
  - DARK: level = 0. fade_in_req -> FADING_IN, counter = 0.
  - FADING_IN: each step increments level. When a step reaches M -> IDLE. fade_out_req -> FADING_OUT, counter = 0.
- Simultaneous events:
  - fade_in_req and fade_out_req in the same cycle: fade_in_req wins.
  - A request coinciding with frame_start: the state transition wins and no step occurs that cycle.
  - fade_out_req in DARK and fade_in_req in IDLE are ignored.
- rst asserted mid-fade returns to IDLE/full brightness on the next edge, and pixels in flight are discarded (outputs 0).

Test Plan:
- Reset, then draw=1, beam_x=200, layer 0 opaque {3,4,5}, layer 1 opaque {9,9,9} -> {3,4,5} 2 cycles later, out_draw=1.
- layer_enable[0]=0, rest as above -> {9,9,9}. All layers transparent -> {15,15,15}. beam_x=160 or 480 -> {0,0,0}.
- highlight_en=1, highlight_layer=1, layer 1 opaque {2,6,10} on top -> {9,13,13}.
- FADE_STEP_FRAMES=1, fade_out_req, then 15 frame_start pulses -> fade_level 15,14,…,0, state DARK, fade_busy falls. Pixel {15,8,3} at level 10 -> {10,3,0}.
- In DARK, assert fade_in_req and fade_out_req together -> FADING_IN. fade_out_req mid-fade-in -> reverses to FADING_OUT from the current level.
- Assert rst during FADING_OUT at level 6 -> next cycle level=15, IDLE, red/green/blue=0, out_draw=0 for 2 cycles.
